// File: rtl/dot_accumulate_seq.sv
// dot_accumulate_seq: sequential dot-product accumulator.
//
// Accepts one packed vector of Ndata unsigned products (2*Nbits each) over a
// valid/ready handshake. It adds one product per clock, then holds the sum
// until the consumer accepts it.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   prod_in    packed products, element 0 in the LSBs
//   in_valid   prod_in is valid
//   in_ready   block can accept a vector (IDLE only)
//   sum_out    dot-product result, stable while out_valid
//   out_valid  sum_out is valid (DONE only)
//   out_ready  consumer accepts sum_out
//   busy       high while accumulating
//   ovf        sticky carry-out flag for the current vector
//
// Build option: define DOT_ACC_SATURATE_EN to clamp the accumulator at
// 2^Accw-1 on overflow. Without it, the accumulator wraps modulo 2^Accw.
// The timing is the same in both builds.

module dot_accumulate_seq #(
  parameter int unsigned Nbits = 4,
  parameter int unsigned Ndata = 8,
  parameter int unsigned Accw  = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [Ndata*2*Nbits-1:0] prod_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [Accw-1:0]          sum_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned Pw    = 2 * Nbits;
  localparam int unsigned VecW  = Ndata * Pw;
  localparam int unsigned CntW  = (Ndata > 1) ? $clog2(Ndata) : 1;
  localparam int unsigned AccW1 = Accw + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Accw-1:0]   acc_q, acc_d;
  logic [Accw-1:0]   sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic [Pw-1:0]     elem;
  logic [Accw:0]     add_full;
  logic [Accw-1:0]   acc_next;
  logic              last;

  // Widen the add by one bit so the carry-out is visible for the ovf flag.
  always_comb begin
    elem     = shift_q[Pw-1:0];
    add_full = {1'b0, acc_q} + AccW1'(elem);
`ifdef DOT_ACC_SATURATE_EN
    // Once clamped, every later add carries again or adds zero, so the value stays at max.
    acc_next = add_full[Accw] ? {Accw{1'b1}} : add_full[Accw-1:0];
`else
    acc_next = add_full[Accw-1:0];
`endif
    last     = (cnt_q == CntW'(Ndata - 1));
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = prod_in;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d   = acc_next;
        ovf_d   = ovf_q | add_full[Accw];
        shift_d = shift_q >> Pw;
        cnt_d   = cnt_q + CntW'(1);
        if (last) begin
          sum_d   = acc_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // The handshake outputs are decoded from the state register, so in_ready and
  // out_valid are never high together.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StAcc);
  assign sum_out   = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_accumulate_seq.sv
// Bench for dot_accumulate_seq. It runs a default instance (Accw=11) and a
// narrow instance (Accw=8) from the same stimulus. Expected sums go into a
// scoreboard queue when a vector is driven, and come out when out_valid is seen.

module tb_dot_accumulate_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] prod_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, busy, ovf;
  logic [10:0] sum_out;
  logic        in_ready8, out_valid8, busy8, ovf8;
  logic [7:0]  sum_out8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_sum[$];
  bit exp_ovf[$];

  dot_accumulate_seq #(.Nbits(4), .Ndata(8), .Accw(11)) dut (
    .clk(clk), .reset_n(reset_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready), .sum_out(sum_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  dot_accumulate_seq #(.Nbits(4), .Ndata(8), .Accw(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready8), .sum_out(sum_out8), .out_valid(out_valid8),
    .out_ready(out_ready), .busy(busy8), .ovf(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the full-precision total, then wrapped or clamped to w bits.
  // A carry happens at some add exactly when the total exceeds the maximum.
  function automatic void model(input logic [63:0] v, input int w, output int s, output bit o);
    int tot = 0;
    int mx = (1 << w) - 1;
    for (int k = 0; k < 8; k++) tot += int'(v[k*8 +: 8]);
    o = (tot > mx);
`ifdef DOT_ACC_SATURATE_EN
    s = o ? mx : tot;
`else
    s = tot % (1 << w);
`endif
  endfunction

  function automatic logic [63:0] pack(input int e0, e1, e2, e3, e4, e5, e6, e7);
    logic [63:0] v;
    v = {8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return v;
  endfunction

  function automatic void push_exp(input logic [63:0] v);
    int s;
    bit o;
    model(v, 11, s, o);
    exp_sum.push_back(s);
    exp_ovf.push_back(o);
  endfunction

  // Call at posedge+1. Waits (bounded) for in_ready, presents v for one accept edge,
  // then returns at posedge+1 just after the accept edge.
  task automatic send(input logic [63:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) return;
    prod_in  = v;
    in_valid = 1'b1;
    push_exp(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the number of edges until out_valid is seen, or -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
    checks++; if (sum_out !== 11'd0) begin errors++; $display("FAIL rst_sum got %0d want 0", sum_out); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int n, es;
    bit eo;
    out_ready = 1'b1;
    send(pack(0, 6, 10, 12, 12, 10, 6, 0), ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout want in_ready"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", n); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_excl got in_ready=%b want 0", in_ready); end
    if (exp_sum.size() == 0) begin
      checks++; errors++; $display("FAIL basic_sb got empty want entry");
    end else begin
      es = exp_sum.pop_front(); eo = exp_ovf.pop_front();
      checks++; if (sum_out !== 11'(es)) begin errors++; $display("FAIL basic_sum got %0d want %0d", sum_out, es); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL basic_ovf got %b want %b", ovf, eo); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_max;
    bit ok;
    int n, es, s8;
    bit eo, o8;
    logic [63:0] v;
    v = pack(225, 225, 225, 225, 225, 225, 225, 225);
    send(v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_accept got timeout want in_ready"); end
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL max_latency got %0d want 8", n); end
    if (exp_sum.size() == 0) begin
      checks++; errors++; $display("FAIL max_sb got empty want entry");
    end else begin
      es = exp_sum.pop_front(); eo = exp_ovf.pop_front();
      checks++; if (sum_out !== 11'(es)) begin errors++; $display("FAIL max_sum got %0d want %0d", sum_out, es); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL max_ovf got %b want %b", ovf, eo); end
    end
    model(v, 8, s8, o8);
    checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL ovf8_valid got %b want 1", out_valid8); end
    checks++; if (sum_out8 !== 8'(s8)) begin errors++; $display("FAIL ovf8_sum got %0d want %0d", sum_out8, s8); end
    checks++; if (ovf8 !== o8) begin errors++; $display("FAIL ovf8_flag got %b want %b", ovf8, o8); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    bit ok;
    int n, es;
    bit eo;
    logic [63:0] ones;
    ones = pack(1, 1, 1, 1, 1, 1, 1, 1);
    out_ready = 1'b0;
    send(pack(3, 5, 7, 9, 11, 13, 15, 17), ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept got timeout want in_ready"); end
    // Second vector is presented while the first is still accumulating.
    prod_in = ones;
    in_valid = 1'b1;
    push_exp(ones);
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL bp_latency got %0d want 8", n); end
    es = (exp_sum.size() != 0) ? exp_sum.pop_front() : -1;
    eo = (exp_ovf.size() != 0) ? exp_ovf.pop_front() : 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sum_out !== 11'(es) || out_valid !== 1'b1 || in_ready !== 1'b0 || ovf !== eo) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%0d v=%b rdy=%b ovf=%b want %0d/1/0/%b",
                 i, sum_out, out_valid, in_ready, ovf, es, eo);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
    in_valid = 1'b0;
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL bp2_latency got %0d want 8", n); end
    if (exp_sum.size() == 0) begin
      checks++; errors++; $display("FAIL bp2_sb got empty want entry");
    end else begin
      es = exp_sum.pop_front(); eo = exp_ovf.pop_front();
      checks++; if (sum_out !== 11'(es)) begin errors++; $display("FAIL bp2_sum got %0d want %0d", sum_out, es); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n, es;
    bit eo;
    send(pack(200, 150, 100, 50, 25, 10, 5, 1), ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_accept got timeout want in_ready"); end
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl got busy=%b rdy=%b v=%b want 0/1/0", busy, in_ready, out_valid);
    end
    checks++; if (sum_out !== 11'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rmid_data got sum=%0d ovf=%b want 0/0", sum_out, ovf);
    end
    exp_sum.delete();
    exp_ovf.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(pack(0, 6, 10, 12, 12, 10, 6, 0), ok);
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL rmid_latency got %0d want 8", n); end
    if (exp_sum.size() == 0) begin
      checks++; errors++; $display("FAIL rmid_sb got empty want entry");
    end else begin
      es = exp_sum.pop_front(); eo = exp_ovf.pop_front();
      checks++; if (sum_out !== 11'(es) || ovf !== eo) begin
        errors++; $display("FAIL rmid_sum got %0d/%b want %0d/%b", sum_out, ovf, es, eo);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] vecs[4];
    int t_prev, t_now, n, es;
    bit eo;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) vecs[i][k*8 +: 8] = 8'($urandom_range(0, 225));
    end
    vecs[1] = '0;
    out_ready = 1'b1;
    t_prev = 0;
    prod_in = vecs[0];
    in_valid = 1'b1;
    push_exp(vecs[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      t_now = cyc;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got busy=%b want 1", i, busy); end
      if (i > 0) begin
        checks++; if (t_now - t_prev != 10) begin
          errors++; $display("FAIL b2b_interval%0d got %0d want 10", i, t_now - t_prev);
        end
      end
      t_prev = t_now;
      if (i < 3) begin
        prod_in = vecs[i+1];
        push_exp(vecs[i+1]);
      end else begin
        in_valid = 1'b0;
      end
      wait_valid(n);
      checks++; if (n != 8) begin errors++; $display("FAIL b2b_latency%0d got %0d want 8", i, n); end
      if (exp_sum.size() == 0) begin
        checks++; errors++; $display("FAIL b2b_sb%0d got empty want entry", i);
      end else begin
        es = exp_sum.pop_front(); eo = exp_ovf.pop_front();
        checks++; if (sum_out !== 11'(es) || ovf !== eo) begin
          errors++; $display("FAIL b2b_sum%0d got %0d/%b want %0d/%b", i, sum_out, ovf, es, eo);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
